// File: rtl/jedro_1_sig_pkg.sv
// Shared types and helpers for the jedro_1 signature monitor.
package jedro_1_sig_pkg;

    // Controller states: arm, watch the core, then walk the signature region.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } sig_state_e;

    localparam int BYTE_BITS = 8;

    // Number of byte lanes on a bus of the given width.
    function automatic int byte_lanes(input int data_width);
        return data_width / BYTE_BITS;
    endfunction

    // Clears the byte-offset bits of an address (lane count is a power of two).
    function automatic logic [63:0] align_down(input logic [63:0] addr, input int lanes);
        return addr & ~(64'(lanes) - 64'd1);
    endfunction

endpackage

// File: rtl/jedro_1_sig_mailbox.sv
// One snooped mailbox word: byte-enable write merge on a matching committed write.
module jedro_1_sig_mailbox
    import jedro_1_sig_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MATCH_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    enable,
    input  logic                    stb,
    input  logic                    ack,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   value_next
);

    localparam int LANES = byte_lanes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] MATCH_ALIGNED =
        ADDR_WIDTH'(align_down(64'(MATCH_ADDR), LANES));

    logic [DATA_WIDTH-1:0] value;
    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic                  hit;

    assign addr_aligned = ADDR_WIDTH'(align_down(64'(addr), LANES));
    assign hit = enable & stb & ack & (|we) & (addr_aligned == MATCH_ALIGNED);

    // Value the mailbox will hold after this cycle, so same-cycle users see the merge.
    always_comb begin
        value_next = value;
        if (hit) begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    value_next[BYTE_BITS*i +: BYTE_BITS] = wdata[BYTE_BITS*i +: BYTE_BITS];
                end
            end
        end
    end

    // Mailbox register, wiped whenever the monitor is re-armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/jedro_1_sig_monitor.sv
// Compliance-test harness controller: snoops mailbox writes, runs a watchdog,
// then streams the signature region read through a dedicated memory port.
module jedro_1_sig_monitor
    import jedro_1_sig_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] SIG_BEGIN_ADDR = 32'h001F_FFFC,
    parameter logic [ADDR_WIDTH-1:0] SIG_END_ADDR   = 32'h001F_FFF8,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR      = 32'h001F_FFF4,
    parameter int unsigned TIMEOUT = 1000000,
    parameter int CNT_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    snoop_stb_i,
    input  logic                    snoop_ack_i,
    input  logic [DATA_WIDTH/8-1:0] snoop_we_i,
    input  logic [ADDR_WIDTH-1:0]   snoop_addr_i,
    input  logic [DATA_WIDTH-1:0]   snoop_wdata_i,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_rvalid_i,
    output logic                    sig_valid_o,
    output logic [DATA_WIDTH-1:0]   sig_data_o,
    output logic                    sig_last_o,
    input  logic                    sig_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    timeout_o,
    output logic [DATA_WIDTH-1:0]   halt_code_o
);

    localparam int LANES = byte_lanes(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST =
        CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    sig_state_e state, state_next;

    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] end_addr;
    logic [ADDR_WIDTH:0]   ptr_plus;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] halt_q;
    logic [DATA_WIDTH-1:0] begin_next;
    logic [DATA_WIDTH-1:0] end_next;
    logic [DATA_WIDTH-1:0] halt_next;
    logic [CNT_WIDTH-1:0]  counter;
    logic                  timeout_q;
    logic                  start_ok;
    logic                  run;
    logic                  halt;
    logic                  expire;
    logic                  last_word;

    assign start_ok = start_i & ((state == ST_IDLE) | (state == ST_DONE));
    assign run      = (state == ST_RUN);

    // The halt mailbox is cleared on arm and any nonzero merge leaves RUN at once,
    // so during RUN its next value is nonzero exactly on a halting write.
    assign halt   = run & (halt_next != '0);
    assign expire = run & (TIMEOUT != 0) & (counter == TIMEOUT_LAST) & ~halt;

    // The extra carry bit marks an address wrap, which always ends the dump.
    assign ptr_plus  = {1'b0, ptr} + (ADDR_WIDTH + 1)'(LANES);
    assign last_word = ptr_plus[ADDR_WIDTH] | (ptr_plus[ADDR_WIDTH-1:0] >= end_addr);

    assign sig_data_o  = data_q;
    assign timeout_o   = timeout_q;
    assign halt_code_o = halt_q;

    jedro_1_sig_mailbox #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MATCH_ADDR (SIG_BEGIN_ADDR)
    ) u_begin_mb (
        .clk        (clk_i),
        .rst        (rst_i),
        .clear      (start_ok),
        .enable     (run),
        .stb        (snoop_stb_i),
        .ack        (snoop_ack_i),
        .we         (snoop_we_i),
        .addr       (snoop_addr_i),
        .wdata      (snoop_wdata_i),
        .value_next (begin_next)
    );

    jedro_1_sig_mailbox #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MATCH_ADDR (SIG_END_ADDR)
    ) u_end_mb (
        .clk        (clk_i),
        .rst        (rst_i),
        .clear      (start_ok),
        .enable     (run),
        .stb        (snoop_stb_i),
        .ack        (snoop_ack_i),
        .we         (snoop_we_i),
        .addr       (snoop_addr_i),
        .wdata      (snoop_wdata_i),
        .value_next (end_next)
    );

    jedro_1_sig_mailbox #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MATCH_ADDR (HALT_ADDR)
    ) u_halt_mb (
        .clk        (clk_i),
        .rst        (rst_i),
        .clear      (start_ok),
        .enable     (run),
        .stb        (snoop_stb_i),
        .ack        (snoop_ack_i),
        .we         (snoop_we_i),
        .addr       (snoop_addr_i),
        .wdata      (snoop_wdata_i),
        .value_next (halt_next)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the state-derived outputs.
    always_comb begin
        state_next  = state;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        sig_valid_o = 1'b0;
        sig_last_o  = 1'b0;
        busy_o      = (state != ST_IDLE) && (state != ST_DONE);
        done_o      = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (start_i) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (halt || expire) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (ptr >= end_addr) begin
                    state_next = ST_DONE;
                end else begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = ptr;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) state_next = ST_EMIT;
            end
            ST_EMIT: begin
                sig_valid_o = 1'b1;
                sig_last_o  = last_word;
                if (sig_ready_i) state_next = last_word ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                if (start_i) state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Watchdog, status latches, dump pointer and the captured read word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr       <= '0;
            end_addr  <= '0;
            data_q    <= '0;
            halt_q    <= '0;
            counter   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (start_ok) begin
                counter   <= '0;
                timeout_q <= 1'b0;
                halt_q    <= '0;
            end
            if (run) begin
                counter <= counter + 1'b1;
                if (halt) halt_q <= halt_next;
                if (expire) timeout_q <= 1'b1;
                if (halt || expire) begin
                    ptr      <= ADDR_WIDTH'(align_down(64'(begin_next), LANES));
                    end_addr <= ADDR_WIDTH'(align_down(64'(end_next), LANES));
                end
            end
            if ((state == ST_WAIT) && mem_rvalid_i) data_q <= mem_rdata_i;
            if ((state == ST_EMIT) && sig_ready_i) ptr <= ptr_plus[ADDR_WIDTH-1:0];
        end
    end

endmodule
